instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the single-cycle datapath's decode/execute logic.
- Owns the fetch PC and issues word requests to an instruction memory with a valid/ready request channel and an in-order, fixed-order response channel.
- Buffers returned words in a small prefetch queue and presents {instruction, pc, pc+4} to the consumer with a valid/ready handshake.
- Flushes and restarts on branch/jump redirects from the execute stage.

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage feeding the single-cycle decode/execute datapath. It owns the
// fetch PC and issues word requests to instruction memory. Returned words go
// into a small in-order prefetch queue. The queue head is offered to the
// consumer as {instruction, pc, pc+4}. A taken branch/jump from execute
// flushes the queue and restarts fetch at the new target. Responses that are
// still in flight at that point are dropped as they arrive.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high; clears all state
//   imem_req_valid   request valid (credit available, not in reset)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word-aligned fetch address (current fetch PC)
//   imem_resp_valid  response valid; in request order, one per accepted request
//   imem_resp_data   returned instruction word
//   redirect_valid   branch/jump taken: flush and restart
//   redirect_pc      new fetch address; bits [1:0] are forced to zero
//   inst_valid       queue head holds a filled instruction
//   inst_ready       consumer accepts the head
//   inst_data        head instruction word
//   inst_pc          head PC
//   inst_pc_plus4    inst_pc + 4, modulo 2^32
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit, so a full queue (DEPTH entries) is
  // distinguishable from an empty one when the index bits match.
  typedef logic [PTR_W:0] ptr_t;

  logic [31:0]      fetch_pc;
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_filled;

  ptr_t alloc_ptr;
  ptr_t fill_ptr;
  ptr_t rd_ptr;
  ptr_t drop_cnt;   // in-flight responses that belong to a flushed stream

  ptr_t             count;        // allocated and not yet read
  ptr_t             pending;      // allocated and not yet filled
  logic [PTR_W+1:0] credit_used;

  logic [PTR_W-1:0] alloc_idx;
  logic [PTR_W-1:0] fill_idx;
  logic [PTR_W-1:0] rd_idx;

  logic req_fire;
  logic resp_live;   // response that matches an outstanding request
  logic pop;

  assign alloc_idx = alloc_ptr[PTR_W-1:0];
  assign fill_idx  = fill_ptr[PTR_W-1:0];
  assign rd_idx    = rd_ptr[PTR_W-1:0];

  assign count       = alloc_ptr - rd_ptr;
  assign pending     = alloc_ptr - fill_ptr;
  assign credit_used = {1'b0, count} + {1'b0, drop_cnt};

  // Every outstanding response (kept or to-be-dropped) needs a credit. This
  // keeps responses landing in a free slot without response backpressure.
  assign imem_req_valid = ~reset & (credit_used < (PTR_W+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_live = imem_resp_valid & ((drop_cnt != '0) | (pending != '0));
  assign pop       = inst_valid & inst_ready;

  // Head outputs come straight from registers: a response becomes visible the
  // cycle after it is written, with no bypass from imem_resp_data.
  assign inst_valid    = (count != '0) & q_filled[rd_idx];
  assign inst_data     = q_data[rd_idx];
  assign inst_pc       = q_pc[rd_idx];
  assign inst_pc_plus4 = inst_pc + 32'd4;

  // NOTE: all state below updates with non-blocking assignments. Every branch
  // then reads the pre-edge values of pointers and counters, whatever order
  // the statements appear in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      drop_cnt  <= '0;
      q_filled  <= '0;
      // NOTE: the queue storage is cleared on reset. The head entry drives
      // inst_data/inst_pc directly, and those must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: in-flight responses for the old stream become drops. That is
      // everything allocated but unfilled, plus a request accepted right now.
      // A response arriving now is one of them, so it is consumed here.
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      q_filled  <= '0;
      fetch_pc  <= redirect_pc & 32'hFFFF_FFFC;
      drop_cnt  <= drop_cnt + pending + ptr_t'(req_fire) - ptr_t'(resp_live);
    end else begin
      if (req_fire) begin
        q_pc[alloc_idx]     <= fetch_pc;
        q_filled[alloc_idx] <= 1'b0;
        alloc_ptr           <= alloc_ptr + ptr_t'(1);
        fetch_pc            <= fetch_pc + 32'd4;
      end
      // A response with nothing outstanding is a protocol error and is ignored.
      if (imem_resp_valid) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - ptr_t'(1);
        end else if (pending != '0) begin
          q_data[fill_idx]   <= imem_resp_data;
          q_filled[fill_idx] <= 1'b1;
          fill_ptr           <= fill_ptr + ptr_t'(1);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Bench for instruction_fetch_unit. A behavioural instruction memory answers
// requests in order after a programmable latency. The returned word is a fixed
// function of the address. The reference model is the architectural view:
// - delivered instructions are consecutive PCs from the last restart point
//   (reset or redirect target), each carrying mem_word(pc);
// - accepted request addresses also run consecutively from that point.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] acc_log[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          n_deliv;
  int          n_acc;
  int          first_acc_cyc;
  int          first_val_cyc;
  logic [31:0] first_del_pc;
  logic [31:0] first_del_data;
  logic [31:0] first_del_plus4;
  logic [31:0] wrap_plus4;
  bit          last_resp;

  logic        rv_s;
  logic        iv_s;
  logic [31:0] ra_s;
  logic [31:0] ip_s;
  logic [31:0] id_s;
  logic [31:0] ip4_s;
  logic [31:0] rpc_r;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply reset from a falling edge, check reset values, release on a falling edge.
  task automatic do_reset();
    reset           = 1'b1;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    repeat (2) @(negedge clk);
    mem_q.delete();
    acc_log.delete();
    exp_pc          = RESET_PC;
    exp_req         = RESET_PC;
    n_deliv         = 0;
    n_acc           = 0;
    first_acc_cyc   = -1;
    first_val_cyc   = -1;
    first_del_pc    = 32'hDEAD_BEEF;
    first_del_data  = 32'hDEAD_BEEF;
    first_del_plus4 = 32'hDEAD_BEEF;
    wrap_plus4      = 32'hDEAD_BEEF;
    reset           = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge. Drives inputs, samples
  // outputs, checks every handshake against the model, then advances the model.
  task automatic step(input bit rq_rdy, input bit in_rdy, input bit redir,
                      input logic [31:0] rpc);
    bit req_f;
    bit del_f;
    bit resp_f;
    int outst;
    imem_req_ready = rq_rdy;
    inst_ready     = in_rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp_f = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = resp_f;
    imem_resp_data  = resp_f ? mem_word(mem_q[0].addr) : $urandom;
    last_resp = resp_f;
    #1;
    rv_s  = imem_req_valid;
    ra_s  = imem_req_addr;
    iv_s  = inst_valid;
    ip_s  = inst_pc;
    id_s  = inst_data;
    ip4_s = inst_pc_plus4;
    req_f = rv_s && rq_rdy;
    del_f = iv_s && in_rdy;
    if (iv_s && first_val_cyc < 0) first_val_cyc = cyc;
    if (req_f) begin
      check("req_addr", ra_s, exp_req);
      outst = mem_q.size() - int'(resp_f) + 1;
      check("outstanding_cap", 32'(outst <= DEPTH), 32'd1);
    end
    if (del_f) begin
      check("inst_pc", ip_s, exp_pc);
      check("inst_data", id_s, mem_word(exp_pc));
      check("inst_pc_plus4", ip4_s, exp_pc + 32'd4);
      if (n_deliv == 0) begin
        first_del_pc    = ip_s;
        first_del_data  = id_s;
        first_del_plus4 = ip4_s;
      end
      if (ip_s == 32'hFFFF_FFFC) wrap_plus4 = ip4_s;
      n_deliv++;
    end
    @(posedge clk);
    if (resp_f) void'(mem_q.pop_front());
    if (req_f) begin
      mem_q.push_back('{addr: ra_s, due: cyc + lat});
      acc_log.push_back(ra_s);
      exp_req = exp_req + 32'd4;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      n_acc++;
    end
    if (del_f) exp_pc = exp_pc + 32'd4;
    if (redir) begin
      exp_pc  = rpc & 32'hFFFF_FFFC;
      exp_req = rpc & 32'hFFFF_FFFC;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Streaming with a 1-cycle memory and an always-ready consumer.
    lat = 1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("t1_accepts", 32'(n_acc), 32'd20);
    check("t1_first_addr", acc_log[0], RESET_PC);
    check("t1_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);
    check("t1_deliveries", 32'(n_deliv), 32'd18);
    check("t1_first_pc", first_del_pc, RESET_PC);
    check("t1_first_plus4", first_del_plus4, RESET_PC + 32'd4);

    // Consumer stalled: credit caps requests at DEPTH, then drains in order.
    do_reset();
    lat = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("t2_accepts", 32'(n_acc), 32'd4);
    check("t2_req_valid_low", 32'(rv_s), 32'd0);
    for (int i = 0; i < 30 && n_deliv < 4; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("t2_drained", 32'(n_deliv >= 4), 32'd1);
    check("t2_first_pc", first_del_pc, RESET_PC);

    // 3-cycle memory, redirect with 3 requests in flight.
    do_reset();
    lat = 3;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    check("t3_in_flight", 32'(mem_q.size()), 32'd3);
    for (int i = 0; i < 40 && n_deliv == 0; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("t3_first_pc", first_del_pc, 32'h0000_0100);
    check("t3_first_data", first_del_data, mem_word(32'h0000_0100));

    // Redirect coinciding with a response and a head handshake.
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
    check("t4_resp_in_redirect", 32'(last_resp), 32'd1);
    check("t4_inst_in_redirect", 32'(iv_s), 32'd1);
    step(1'b0, 1'b0, 1'b0, '0);
    check("t4_next_addr", ra_s, 32'h0000_0200);
    check("t4_next_req_valid", 32'(rv_s), 32'd1);
    check("t4_queue_empty", 32'(iv_s), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Fetch PC wrap-around at the top of the address space.
    do_reset();
    lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    acc_log.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
    check("t5_req0", acc_log[0], 32'hFFFF_FFF8);
    check("t5_req1", acc_log[1], 32'hFFFF_FFFC);
    check("t5_req2", acc_log[2], 32'h0000_0000);
    check("t5_plus4_wrap", wrap_plus4, 32'h0000_0000);

    // Asynchronous reset between edges with two filled entries queued.
    do_reset();
    lat = 1;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    imem_resp_valid = 1'b0;
    #1;
    check("t6_pre_inst_valid", 32'(inst_valid), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    check("t6_restart_accepts", 32'(n_acc), 32'd1);
    check("t6_restart_addr", acc_log[0], RESET_PC);

    // Randomized traffic: memory latency, both readies and redirects.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) lat = $urandom_range(1, 4);
      case ($urandom_range(0, 2))
        0:       rpc_r = $urandom;
        1:       rpc_r = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: rpc_r = 32'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, rpc_r);
    end
    check("rand_progress", 32'(n_deliv > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
